// File: rtl/unidade_multdiv.sv
// rtl/unidade_multdiv.sv - iterative 32-bit multiply/divide unit producing hi/lo for mult, multu, div, divu
module unidade_multdiv #(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inicio,
    input  logic [1:0]         operacao,
    input  logic [LARGURA-1:0] entrada_a,
    input  logic [LARGURA-1:0] entrada_b,
    output logic               ocupado,
    output logic               pronto,
    output logic               div_zero,
    output logic [LARGURA-1:0] hi,
    output logic [LARGURA-1:0] lo
);

    localparam int CW = $clog2(LARGURA);
    localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULO = 2'd1,
        AJUSTE  = 2'd2
    } estado_t;

    estado_t estado, estado_prox;

    logic [1:0]           op;
    logic [LARGURA-1:0]   a_lat, b_lat;
    logic                 sinal_a, sinal_b;
    logic [CW-1:0]        cont;
    logic [2*LARGURA-1:0] acc, acc_prox, produto;

    logic                 e_div, com_sinal;
    logic                 in_com_sinal;
    logic [LARGURA-1:0]   a_in, b_in;
    logic [LARGURA:0]     soma, tentativa, diferenca;
    logic [LARGURA-1:0]   quoc, resto, res_hi, res_lo;

    assign e_div     = op[1];
    assign com_sinal = ~op[0];

    // Signed operands are reduced to magnitudes; 0x80000000 maps to itself, which is 2^31 unsigned.
    assign in_com_sinal = ~operacao[0];
    assign a_in = (in_com_sinal && entrada_a[LARGURA-1]) ? (~entrada_a + LARGURA'(1)) : entrada_a;
    assign b_in = (in_com_sinal && entrada_b[LARGURA-1]) ? (~entrada_b + LARGURA'(1)) : entrada_b;

    // Multiply keeps the multiplier in the low half; divide keeps remainder:dividend/quotient.
    always_comb begin
        soma      = {1'b0, acc[2*LARGURA-1:LARGURA]} + (acc[0] ? {1'b0, a_lat} : '0);
        tentativa = acc[2*LARGURA-1:LARGURA-1];
        diferenca = tentativa - {1'b0, b_lat};
        acc_prox  = acc;
        if (e_div) begin
            if (diferenca[LARGURA])
                acc_prox = {tentativa[LARGURA-1:0], acc[LARGURA-2:0], 1'b0};
            else
                acc_prox = {diferenca[LARGURA-1:0], acc[LARGURA-2:0], 1'b1};
        end else begin
            acc_prox = {soma, acc[LARGURA-1:1]};
        end
    end

    always_comb begin
        produto = (com_sinal && (sinal_a ^ sinal_b)) ? (~acc + (2*LARGURA)'(1)) : acc;
        quoc    = acc[LARGURA-1:0];
        resto   = acc[2*LARGURA-1:LARGURA];
        res_hi  = produto[2*LARGURA-1:LARGURA];
        res_lo  = produto[LARGURA-1:0];
        if (e_div) begin
            if (b_lat == '0) begin
                res_hi = a_lat;
                res_lo = '1;
            end else begin
                res_lo = (com_sinal && (sinal_a ^ sinal_b)) ? (~quoc + LARGURA'(1)) : quoc;
                res_hi = (com_sinal && sinal_a) ? (~resto + LARGURA'(1)) : resto;
            end
        end
    end

    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO:  if (inicio) estado_prox = CALCULO;
            CALCULO: if (cont == ULTIMO) estado_prox = AJUSTE;
            AJUSTE:  estado_prox = OCIOSO;
            default: estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) estado <= OCIOSO;
        else        estado <= estado_prox;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            op       <= '0;
            a_lat    <= '0;
            b_lat    <= '0;
            sinal_a  <= 1'b0;
            sinal_b  <= 1'b0;
            cont     <= '0;
            acc      <= '0;
            ocupado  <= 1'b0;
            pronto   <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (inicio) begin
                        op       <= operacao;
                        a_lat    <= a_in;
                        b_lat    <= b_in;
                        sinal_a  <= in_com_sinal && entrada_a[LARGURA-1];
                        sinal_b  <= in_com_sinal && entrada_b[LARGURA-1];
                        cont     <= '0;
                        acc      <= {{LARGURA{1'b0}}, (operacao[1] ? a_in : b_in)};
                        div_zero <= 1'b0;
                        ocupado  <= 1'b1;
                    end
                end
                CALCULO: begin
                    acc  <= acc_prox;
                    cont <= cont + 1'b1;
                end
                AJUSTE: begin
                    hi       <= res_hi;
                    lo       <= res_lo;
                    div_zero <= e_div && (b_lat == '0);
                    pronto   <= 1'b1;
                    ocupado  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/unidade_multdiv.md
Name: unidade_multdiv

Overview:
- Iterative 32-bit multiply/divide unit for the datapath; produces the HI/LO pair for mult, multu, div and divu.
- Sits directly upstream of the write-back result mux2x1. `hi` or `lo` (chosen for mfhi/mflo) drives that mux's `entrada1`; the ALU result drives `entrada0`.
- Control holds the pipeline/FSM while `ocupado` is high and resumes on `pronto`.

Parameters:
- LARGURA, 32, operand width in bits. It also sets the iteration count; only 32 is exercised.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of `clock`.
- inicio  input  1  start request; sampled only in state OCIOSO.
- operacao  input  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- entrada_a  input  LARGURA  multiplicand / dividend.
- entrada_b  input  LARGURA  multiplier / divisor.
- ocupado  output  1  high while an operation is in progress.
- pronto  output  1  one-cycle pulse when `hi`/`lo` have just been updated.
- div_zero  output  1  set with `pronto` when a div/divu had divisor 0; held until the next accepted start.
- hi  output  LARGURA  product upper word / remainder.
- lo  output  LARGURA  product lower word / quotient.

Behaviour:
- Reset (`reset`=0 at an edge): state OCIOSO; `ocupado`=0, `pronto`=0, `div_zero`=0, `hi`=0, `lo`=0, internal counter/accumulators=0.
- Reset wins over every other event, including mid-operation. Any in-flight operation is aborted and no `pronto` is produced.
- State OCIOSO:
  - On `inicio`=1, latch `operacao`. For signed ops, latch |a|, |b| and the sign bits; for unsigned ops, latch a and b raw.
  - Clear counter and `div_zero`, set `ocupado`=1, go to CALCULO.
- State CALCULO: exactly LARGURA cycles, one iteration per edge.
  - Multiply: shift-add on a 2*LARGURA accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle (MSB first).
  - After the LARGURA-th iteration, go to AJUSTE.
- State AJUSTE, one cycle:
  - Apply sign correction and write `hi`/`lo`.
  - Assert `pronto`=1 for the following cycle only, drop `ocupado`, return to OCIOSO.
- Latency: start accepted at edge E0 → `hi`/`lo` updated and `pronto` high after edge E0+LARGURA+1 (33 for 32-bit). `ocupado` is high from after E0 until that same edge.
- `inicio` while `ocupado`=1 is ignored, with no queueing. `inicio` in the same cycle `pronto` is high is accepted (state is already OCIOSO).
- Operands are sampled only at acceptance; later changes on `entrada_a`/`entrada_b`/`operacao` have no effect.
- `hi`/`lo` hold their last value between operations and during a new operation until its AJUSTE.
- mult: the 64-bit product is negated if sign_a ^ sign_b. multu: plain unsigned product.
- div:
  - The magnitude quotient is negated if sign_a ^ sign_b; the remainder is negated if sign_a, so it takes the dividend's sign.
  - Overflow case 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- Divide by zero (b=0, div or divu):
  - Normal timing. `lo`=0xFFFFFFFF, `hi`=entrada_a as latched, `div_zero`=1.
  - No sign correction is applied in this case.
- Flags: no other exceptions; no overflow flag for mult.

Test Plan:
- Reset, then multu 0xFFFFFFFF × 0xFFFFFFFF → `pronto` exactly 33 cycles after the start edge; `hi`=0xFFFFFFFE, `lo`=0x00000001; `ocupado` high for exactly 33 cycles.
- mult −3 (0xFFFFFFFD) × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1; then mult 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
- div −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; divu 100 / 7 → `lo`=14, `hi`=2; div 0x80000000 / −1 → `lo`=0x80000000, `hi`=0.
- divu 0x1234 / 0 → `lo`=0xFFFFFFFF, `hi`=0x1234, `div_zero`=1; the next accepted start clears `div_zero`.
- Start multu 6×7, pulse `inicio` with a different op at cycle 10 → ignored; result `lo`=42, `hi`=0. Back-to-back `inicio` in the `pronto` cycle → second op accepted.
- Assert reset at cycle 15 of a div → `ocupado`=0, `hi`=`lo`=0, no `pronto` pulse; a new op after reset completes correctly.
